ov7670_sccb_init: RTL and testbench
===================================

OV7670_SCCB_INIT -- requirements
Module: ov7670_sccb_init

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 25_000_000: frequency of clk (the VGA-domain 25 MHz clock).
REQ-002 Parameter SCCB_FREQ_HZ, default 100_000: SIOC rate; Q = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) clocks per quarter-bit (62 at defaults).
REQ-003 Parameter DELAY_CYCLES, default 250_000: wait length for a delay table entry (10 ms at 25 MHz).
REQ-004 Parameter AUTO_START, default 1: when 1, run the table once after reset release without a start pulse.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  one-cycle request to (re)run the whole table; sampled only in IDLE or DONE.
REQ-008 sioc  output  1  SCCB clock, push-pull.
REQ-009 siod_out  output  1  SCCB data value, valid when siod_oe=1.
REQ-010 siod_oe  output  1  1 = drive siod_out, 0 = release (top level tri-states the pad).
REQ-011 busy  output  1  high from leaving IDLE/DONE until DONE is entered.
REQ-012 done  output  1  level, high in DONE; cleared when a new run starts.
REQ-013 reg_idx  output  8  index of the table entry in progress.

Function
REQ-014 The table is a 16-bit-per-entry ROM {sub_addr[15:8], data[7:0]} indexed by reg_idx; 16'hFFF0 = delay marker, 16'hFFFF = end marker.
REQ-015 FSM states: IDLE, LOAD, START, BITS, STOP, GAP, DELAY, DONE.
REQ-016 IDLE: sioc=1, siod_oe=0; go to LOAD on start=1 or on the first cycle after reset release if AUTO_START=1; reg_idx <= 0.
REQ-017 LOAD: fetch entry; FFFF -> DONE; FFF0 -> DELAY; otherwise latch shift word {8'h42,1'b0,sub,1'b0,data,1'b0} (27 bits) -> START; 1 cycle.
REQ-018 START: siod_oe=1, siod_out=0 with sioc=1 for 2Q clocks, then sioc=0 -> BITS.
REQ-019 BITS: 27 bits MSB first, 4Q clocks each; quarter 0 updates siod and holds sioc=0; quarters 0-1 sioc=0; quarters 2-3 sioc=1.
REQ-020 The 9th, 18th and 27th bits (don't-care/ACK slots) drive siod_oe=0 for the whole bit; ACK is not checked.
REQ-021 STOP: siod_oe=1, siod_out=0, sioc=0 for Q; sioc=1 for Q; then siod_oe=0 -> GAP.
REQ-022 GAP: bus idle (sioc=1, siod_oe=0) for 4Q clocks, then reg_idx+1 -> LOAD.
REQ-023 One write = 2Q+108Q+2Q+4Q+1 = 116Q+1 clocks from LOAD to next LOAD (7193 at defaults).
REQ-024 DELAY: bus idle for DELAY_CYCLES clocks, then reg_idx+1 -> LOAD.
REQ-025 DONE: done=1, busy=0, bus idle; start=1 -> reg_idx <= 0, done <= 0, LOAD.
REQ-026 start while busy=1 is ignored, not queued.
REQ-027 reg_idx saturates at 255; reaching 255 without an end marker -> DONE.
REQ-028 Quarter and delay counters are sized with $clog2 of their maxima; no counter wraps inside a phase.

Reset
REQ-029 rst=0 at a clock edge: state=IDLE, sioc=1, siod_out=1, siod_oe=0, busy=0, done=0, reg_idx=0, all counters 0.
REQ-030 Reset mid-transaction aborts it within one cycle; the camera sees a truncated frame, and the next run restarts from entry 0.

Structure
REQ-031 Shared include ov7670_defs.vh holds SCCB_ID (8'h42), DELAY_MARK (16'hFFF0), END_MARK (16'hFFFF) and state encodings.
REQ-032 Sub-module ov7670_reg_rom (combinational, 8-bit index -> 16-bit entry); entries 0-2 = 16'h1280, 16'hFFF0, 16'h1214; remaining content is owned by the camera-format spec.

Verification
REQ-033 Reset release, AUTO_START=1, Q=2 -> first START at cycle 2; bit stream 0x42,X,0x12,X,0x80,X decoded at sioc rising edges.
REQ-034 Entry FFF0, DELAY_CYCLES=100 -> sioc=1 and siod_oe=0 for exactly 100 clocks between STOP of entry 0 and START of entry 2.
REQ-035 Table {0x1280, FFFF} -> done=1 and busy=0 after 116Q+1+1 clocks; no further sioc edges.
REQ-036 start pulse during BITS -> ignored; start pulse in DONE -> reg_idx=0, done=0, and the bus replays entry 0.
REQ-037 rst=0 during bit 10 -> next cycle sioc=1, siod_oe=0, busy=0; after release the run restarts at reg_idx=0.
REQ-038 Checker on every run: siod changes only while sioc=0, except for the START and STOP edges.

Source files
------------

// File: rtl/ov7670_sccb_init_pkg.sv
// ov7670_sccb_init_pkg
// Shared constants, state encoding and helpers for the OV7670 SCCB register
// initialiser: camera write ID, table marker words, FSM states, the 27-bit
// write-frame builder and the don't-care/ACK slot decoder.
package ov7670_sccb_init_pkg;

    localparam logic [7:0]  SCCB_ID    = 8'h42;
    localparam logic [15:0] DELAY_MARK = 16'hFFF0;
    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam int          FRAME_BITS = 27;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_BITS  = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DELAY = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Three-phase write: ID, sub-address, data, each followed by a
    // don't-care slot where the master releases the line.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [15:0] entry);
        return {SCCB_ID, 1'b0, entry[15:8], 1'b0, entry[7:0], 1'b0};
    endfunction

    function automatic logic is_ack_slot(input logic [4:0] bit_idx);
        return (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// ov7670_reg_rom
// Combinational register table for the OV7670 initialiser.
// Each entry is {sub_addr[15:8], data[7:0]}; 16'hFFF0 requests a delay and
// 16'hFFFF terminates the table.
// Ports:
//   idx   in   8  table index
//   entry out 16  table word at idx
module ov7670_reg_rom
    import ov7670_sccb_init_pkg::*;
(
    input  logic [7:0]  idx,
    output logic [15:0] entry
);

    always_comb begin
        entry = END_MARK;
        case (idx)
            8'd0:    entry = 16'h1280;   // COM7: soft reset
            8'd1:    entry = DELAY_MARK; // let the reset settle
            8'd2:    entry = 16'h1214;   // COM7: QVGA, RGB output
            8'd3:    entry = 16'h40D0;   // COM15: RGB565, full range
            8'd4:    entry = 16'h3A04;   // TSLB: fixed output window
            8'd5:    entry = 16'h8C00;   // RGB444 disabled
            8'd6:    entry = 16'h1180;   // CLKRC: use external clock directly
            default: entry = END_MARK;
        endcase
    end

endmodule

// File: rtl/ov7670_sccb_init.sv
// ov7670_sccb_init
// Walks the OV7670 register table once per run and emits each entry as an
// SCCB 3-phase write (ID 0x42, sub-address, data). Delay markers idle the bus
// for DELAY_CYCLES clocks; the end marker (or index 255) finishes the run.
// Ports:
//   clk       in   1  single clock, rising edge
//   rst       in   1  synchronous, active-low reset
//   start     in   1  one-cycle run request, honoured only in IDLE/DONE
//   sioc      out  1  SCCB clock (push-pull)
//   siod_out  out  1  SCCB data value when siod_oe=1
//   siod_oe   out  1  1 = drive siod, 0 = release to the pull-up
//   busy      out  1  a run is in progress
//   done      out  1  run finished; cleared by the next start
//   reg_idx   out  8  table entry in progress
module ov7670_sccb_init
    import ov7670_sccb_init_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 25_000_000,
    parameter int SCCB_FREQ_HZ = 100_000,
    parameter int DELAY_CYCLES = 250_000,
    parameter bit AUTO_START   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       sioc,
    output logic       siod_out,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [7:0] reg_idx
);

    localparam int Q  = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int QW = (Q > 1) ? $clog2(Q) : 1;
    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(Q - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DELAY_CYCLES - 1);

    state_t                  state_reg, state_next;
    logic [QW-1:0]           q_cnt_reg, q_cnt_next;
    logic [1:0]              phase_reg, phase_next;
    logic [4:0]              bit_cnt_reg, bit_cnt_next;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic [DW-1:0]           delay_cnt_reg, delay_cnt_next;
    logic [7:0]              reg_idx_reg, reg_idx_next;
    logic                    auto_reg, auto_next;
    logic                    sioc_reg, sioc_next;
    logic                    siod_out_reg, siod_out_next;
    logic                    siod_oe_reg, siod_oe_next;
    logic                    quarter_end;
    logic                    advance;
    logic [15:0]             rom_entry;

    ov7670_reg_rom u_rom (
        .idx   (reg_idx_reg),
        .entry (rom_entry)
    );

    assign quarter_end = (q_cnt_reg == Q_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            q_cnt_reg     <= '0;
            phase_reg     <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            delay_cnt_reg <= '0;
            reg_idx_reg   <= '0;
            auto_reg      <= AUTO_START;
            sioc_reg      <= 1'b1;
            siod_out_reg  <= 1'b1;
            siod_oe_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            q_cnt_reg     <= q_cnt_next;
            phase_reg     <= phase_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            delay_cnt_reg <= delay_cnt_next;
            reg_idx_reg   <= reg_idx_next;
            auto_reg      <= auto_next;
            sioc_reg      <= sioc_next;
            siod_out_reg  <= siod_out_next;
            siod_oe_reg   <= siod_oe_next;
        end
    end

    // Bus pins are registered from the current state, so the pad waveform
    // trails the state register by one clock; every phase keeps its length.
    always_comb begin
        state_next     = state_reg;
        q_cnt_next     = q_cnt_reg;
        phase_next     = phase_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        delay_cnt_next = delay_cnt_reg;
        reg_idx_next   = reg_idx_reg;
        auto_next      = auto_reg;
        sioc_next      = 1'b1;
        siod_out_next  = 1'b1;
        siod_oe_next   = 1'b0;
        advance        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start || auto_reg) begin
                    state_next   = ST_LOAD;
                    reg_idx_next = '0;
                    auto_next    = 1'b0;
                end
            end

            ST_LOAD: begin
                q_cnt_next = '0;
                phase_next = '0;
                if (rom_entry == END_MARK) begin
                    state_next = ST_DONE;
                end else if (rom_entry == DELAY_MARK) begin
                    delay_cnt_next = '0;
                    state_next     = ST_DELAY;
                end else begin
                    shift_next = build_frame(rom_entry);
                    state_next = ST_START;
                end
            end

            ST_START: begin
                siod_out_next = 1'b0;
                siod_oe_next  = 1'b1;
                q_cnt_next    = quarter_end ? '0 : q_cnt_reg + 1'b1;
                if (quarter_end) begin
                    if (phase_reg == 2'd1) begin
                        phase_next   = '0;
                        bit_cnt_next = '0;
                        state_next   = ST_BITS;
                    end else begin
                        phase_next = phase_reg + 2'd1;
                    end
                end
            end

            ST_BITS: begin
                sioc_next  = phase_reg[1];
                q_cnt_next = quarter_end ? '0 : q_cnt_reg + 1'b1;
                // First clock of a low quarter keeps the old data so SIOD
                // never moves on the same edge that SIOC falls.
                if (phase_reg == 2'd0 && q_cnt_reg == '0) begin
                    siod_out_next = siod_out_reg;
                    siod_oe_next  = siod_oe_reg;
                end else begin
                    siod_out_next = shift_reg[FRAME_BITS-1];
                    siod_oe_next  = !is_ack_slot(bit_cnt_reg);
                end
                if (quarter_end) begin
                    phase_next = phase_reg + 2'd1;
                    if (phase_reg == 2'd3) begin
                        phase_next = '0;
                        shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
                        if (bit_cnt_reg == 5'(FRAME_BITS - 1)) begin
                            state_next = ST_STOP;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 5'd1;
                        end
                    end
                end
            end

            ST_STOP: begin
                sioc_next  = phase_reg[0];
                q_cnt_next = quarter_end ? '0 : q_cnt_reg + 1'b1;
                if (phase_reg == 2'd0 && q_cnt_reg == '0) begin
                    siod_out_next = siod_out_reg;
                    siod_oe_next  = siod_oe_reg;
                end else begin
                    siod_out_next = 1'b0;
                    siod_oe_next  = 1'b1;
                end
                if (quarter_end) begin
                    if (phase_reg == 2'd1) begin
                        phase_next = '0;
                        state_next = ST_GAP;
                    end else begin
                        phase_next = phase_reg + 2'd1;
                    end
                end
            end

            ST_GAP: begin
                q_cnt_next = quarter_end ? '0 : q_cnt_reg + 1'b1;
                if (quarter_end) begin
                    if (phase_reg == 2'd3) begin
                        phase_next = '0;
                        advance    = 1'b1;
                    end else begin
                        phase_next = phase_reg + 2'd1;
                    end
                end
            end

            ST_DELAY: begin
                if (delay_cnt_reg == D_LAST) begin
                    delay_cnt_next = '0;
                    advance        = 1'b1;
                end else begin
                    delay_cnt_next = delay_cnt_reg + 1'b1;
                end
            end

            ST_DONE: begin
                if (start) begin
                    reg_idx_next = '0;
                    state_next   = ST_LOAD;
                end
            end

            default: state_next = ST_IDLE;
        endcase

        // A table without an end marker stops after the last index.
        if (advance) begin
            if (reg_idx_reg == 8'hFF) begin
                state_next = ST_DONE;
            end else begin
                reg_idx_next = reg_idx_reg + 8'd1;
                state_next   = ST_LOAD;
            end
        end
    end

    assign sioc     = sioc_reg;
    assign siod_out = siod_out_reg;
    assign siod_oe  = siod_oe_reg;
    assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done     = (state_reg == ST_DONE);
    assign reg_idx  = reg_idx_reg;

endmodule

// File: tb/tb_ov7670_sccb_init.sv
// tb_ov7670_sccb_init
// Self-checking bench for ov7670_sccb_init with Q=2 and a 100-clock delay.
// A bus monitor decodes START/STOP/bits from the pins and compares them with
// a scoreboard of frames and idle gaps queued when each run is launched.
module tb_ov7670_sccb_init;

    localparam int CLK_HZ       = 800;
    localparam int SCCB_HZ      = 100;
    localparam int Q            = 2;
    localparam int D            = 100;
    localparam int WRITE_CYCLES = 116 * Q + 1;
    localparam int GAP_CYCLES   = 4 * Q + 1;
    localparam logic [15:0] TABLE [8] = '{16'h1280, 16'hFFF0, 16'h1214, 16'h40D0,
                                          16'h3A04, 16'h8C00, 16'h1180, 16'hFFFF};
    localparam logic [26:0] OE_PATTERN = {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       sioc, siod_out, siod_oe, busy, done;
    logic [7:0] reg_idx;
    logic       sda;

    ov7670_sccb_init #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .SCCB_FREQ_HZ (SCCB_HZ),
        .DELAY_CYCLES (D),
        .AUTO_START   (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sioc     (sioc),
        .siod_out (siod_out),
        .siod_oe  (siod_oe),
        .busy     (busy),
        .done     (done),
        .reg_idx  (reg_idx)
    );

    always #5 clk = ~clk;

    // Pull-up on the data line.
    assign sda = siod_oe ? siod_out : 1'b1;

    int          errors = 0;
    int          checks = 0;
    int          run_n = 0;
    int          first_start_n = -1;
    int          exp_done_n = 0;
    int          exp_end_idx = 0;
    logic [23:0] exp_frames[$];
    int          exp_gaps[$];
    logic        mon_en = 1'b0;
    logic        prev_sioc = 1'b1;
    logic        prev_sda = 1'b1;
    logic        in_frame = 1'b0;
    logic        have_stop = 1'b0;
    int          nbits = 0;
    int          stop_n = 0;
    int          sioc_edges = 0;
    logic [26:0] frame_bits = '0;
    logic [26:0] oe_bits = '0;

    task automatic monitor();
        logic [23:0] e;
        logic [23:0] got;
        int          g;
        if (mon_en) begin
            if (sioc !== prev_sioc) sioc_edges++;
            if (sda !== prev_sda) begin
                checks++;
                if (sioc && prev_sioc) begin
                    if (!sda) begin
                        $display("start condition at cycle %0d", run_n);
                        if (first_start_n < 0) first_start_n = run_n;
                        if (have_stop) begin
                            if (exp_gaps.size() == 0) begin
                                errors++;
                                $display("FAIL gap_unexpected: idle=%0d cycles, required no frame", run_n - stop_n);
                            end else begin
                                g = exp_gaps.pop_front();
                                if (run_n - stop_n != g) begin
                                    errors++;
                                    $display("FAIL bus_gap: idle=%0d cycles, required %0d", run_n - stop_n, g);
                                end
                            end
                        end
                        in_frame   = 1'b1;
                        nbits      = 0;
                        frame_bits = '0;
                        oe_bits    = '0;
                    end else begin
                        got = {frame_bits[26:19], frame_bits[17:10], frame_bits[8:1]};
                        $display("stop condition at cycle %0d frame=%06h clocks=%0d", run_n, got, nbits);
                        if (exp_frames.size() == 0) begin
                            errors++;
                            $display("FAIL frame_unexpected: got %06h, required none", got);
                        end else begin
                            e = exp_frames.pop_front();
                            if (got !== e) begin
                                errors++;
                                $display("FAIL frame_data: got %06h, required %06h", got, e);
                            end
                        end
                        // 27 data clocks plus the SIOC pulse of the STOP phase
                        checks++;
                        if (nbits != 28) begin
                            errors++;
                            $display("FAIL frame_clocks: got %0d, required 28", nbits);
                        end
                        checks++;
                        if (oe_bits !== OE_PATTERN) begin
                            errors++;
                            $display("FAIL ack_release: got %07h, required %07h", oe_bits, OE_PATTERN);
                        end
                        in_frame  = 1'b0;
                        have_stop = 1'b1;
                        stop_n    = run_n;
                    end
                end else if (sioc || prev_sioc) begin
                    errors++;
                    $display("FAIL siod_edge: siod moved with sioc %0b->%0b at cycle %0d, required sioc low", prev_sioc, sioc, run_n);
                end
            end
            if (sioc && !prev_sioc && in_frame) begin
                if (nbits < 27) begin
                    frame_bits = {frame_bits[25:0], sda};
                    oe_bits    = {oe_bits[25:0], siod_oe};
                end
                nbits++;
            end
        end else begin
            in_frame = 1'b0;
        end
        prev_sioc = sioc;
        prev_sda  = sda;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        run_n++;
        monitor();
    endtask

    // Queue the frames and idle gaps a full table run must produce.
    task automatic push_run();
        int  total;
        int  pending;
        logic found;
        exp_frames.delete();
        exp_gaps.delete();
        have_stop = 1'b0;
        total     = 0;
        pending   = -1;
        found     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found) begin
                if (TABLE[i] == 16'hFFFF) begin
                    found       = 1'b1;
                    exp_end_idx = i;
                end else if (TABLE[i] == 16'hFFF0) begin
                    total += 1 + D;
                    if (pending >= 0) pending += D + 1;
                end else begin
                    total += WRITE_CYCLES;
                    if (pending >= 0) exp_gaps.push_back(pending);
                    exp_frames.push_back({8'h42, TABLE[i]});
                    pending = GAP_CYCLES;
                end
            end
        end
        // one LOAD->DONE edge, plus counting starts at 1 after the launch edge
        exp_done_n    = total + 2;
        run_n         = 0;
        first_start_n = -1;
    endtask

    task automatic finish_run(input string name);
        while (!done && run_n < exp_done_n + 50) tick();
        checks++;
        if (run_n != exp_done_n || !done) begin
            errors++;
            $display("FAIL %s_done_cycle: done=%0b at %0d, required 1 at %0d", name, done, run_n, exp_done_n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_end: got %0b, required 0", name, busy);
        end
        checks++;
        if (reg_idx !== 8'(exp_end_idx)) begin
            errors++;
            $display("FAIL %s_end_idx: got %0d, required %0d", name, reg_idx, exp_end_idx);
        end
        checks++;
        if (first_start_n - 1 != 2) begin
            errors++;
            $display("FAIL %s_first_start: edge %0d, required 2", name, first_start_n - 1);
        end
        checks++;
        if (exp_frames.size() != 0 || exp_gaps.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: frames=%0d gaps=%0d left, required 0", name, exp_frames.size(), exp_gaps.size());
        end
        $display("%s: done at cycle %0d", name, run_n);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({sioc, siod_out, siod_oe, busy, done} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_pins: sioc,siod_out,siod_oe,busy,done=%05b, required 11000", {sioc, siod_out, siod_oe, busy, done});
        end
        checks++;
        if (reg_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_idx: got %0d, required 0", reg_idx);
        end
    endtask

    task automatic test_auto_start();
        push_run();
        mon_en = 1'b1;
        rst    = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || reg_idx !== 8'd0) begin
            errors++;
            $display("FAIL auto_launch: busy=%0b idx=%0d, required busy=1 idx=0", busy, reg_idx);
        end
        finish_run("auto");
    endtask

    task automatic test_quiet_after_done();
        sioc_edges = 0;
        repeat (40) tick();
        checks++;
        if (sioc_edges != 0 || siod_oe !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL quiet_done: sioc edges=%0d oe=%0b done=%0b, required 0/0/1", sioc_edges, siod_oe, done);
        end
    endtask

    task automatic test_restart_and_busy_start();
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (reg_idx !== 8'd0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: idx=%0d done=%0b busy=%0b, required 0/0/1", reg_idx, done, busy);
        end
        while (!(in_frame && nbits == 5) && run_n < 500) tick();
        checks++;
        if (!(in_frame && nbits == 5)) begin
            errors++;
            $display("FAIL bits_wait: nbits=%0d, required 5 within 500 cycles", nbits);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (reg_idx !== 8'd0 || busy !== 1'b1 || !in_frame) begin
            errors++;
            $display("FAIL busy_start: idx=%0d busy=%0b in_frame=%0b, required 0/1/1", reg_idx, busy, in_frame);
        end
        finish_run("replay");
    endtask

    task automatic test_reset_mid_frame();
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!(in_frame && nbits == 10) && run_n < 500) tick();
        checks++;
        if (!(in_frame && nbits == 10)) begin
            errors++;
            $display("FAIL bit10_wait: nbits=%0d, required 10 within 500 cycles", nbits);
        end
        rst    = 1'b0;
        mon_en = 1'b0;
        tick();
        checks++;
        if ({sioc, siod_oe, busy, done} !== 4'b1000 || reg_idx !== 8'd0) begin
            errors++;
            $display("FAIL abort: sioc,oe,busy,done=%04b idx=%0d, required 1000 idx=0", {sioc, siod_oe, busy, done}, reg_idx);
        end
        tick();
        push_run();
        mon_en = 1'b1;
        rst    = 1'b1;
        finish_run("after_abort");
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_quiet_after_done();
        test_restart_and_busy_start();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
